// File: rtl/if_id_stage_pkg.sv
// Shared front-end definitions: datapath width, reset/bubble constants,
// fetch FSM encoding and the RV32I major opcodes decoded by the control unit.
package if_id_stage_pkg;

    localparam int          IF_XLEN      = 32;
    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request presented to imem
        S_WAIT = 2'd1,  // one fetch in flight, waiting for its word
        S_HOLD = 2'd2,  // word parked in skid while ID is stalled
        S_DROP = 2'd3   // stale fetch in flight after a redirect
    } if_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding buffer for a fetched word that arrives while ID is stalled.
// A load in the same cycle as clear/drain wins: the new word is younger.
module if_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] ld_pc,
    input  logic [XLEN-1:0] ld_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    // Entry state: load captures, drain/clear empty it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= ld_pc;
            instr <= ld_instr;
        end else if (clear || drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch + IF/ID register. Keeps at most one fetch outstanding,
// parks a word in the skid buffer when ID is stalled, and discards the word
// of a fetch that was overtaken by a redirect.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int              XLEN      = IF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = IF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [XLEN-1:0] id_instr,
    output logic [6:0]      Op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd
);

    if_state_e       state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] fetch_pc;     // address of the fetch currently in flight
    logic [XLEN-1:0] redirect_tgt;
    logic            fire;
    logic            rsp_live;     // response that belongs in the pipe
    logic            skid_valid, skid_load, skid_drain, skid_clear;
    logic [XLEN-1:0] skid_pc, skid_instr;

    // Request is held low for the whole reset window
    assign imem_req_valid = rst && (state == S_REQ);
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;
    assign rsp_live       = imem_rsp_valid && (state == S_WAIT) && !redirect_valid;
    assign redirect_tgt   = redirect_pc & ~(XLEN'(3));

    // Skid control: redirect/flush wipe it, a stalled live response fills it
    always_comb begin
        skid_clear = redirect_valid || flush;
        skid_load  = rsp_live && stall;
        skid_drain = (state == S_HOLD) && skid_valid && !stall && !flush && !redirect_valid;
    end

    if_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .drain    (skid_drain),
        .clear    (skid_clear),
        .ld_pc    (fetch_pc),
        .ld_instr (imem_rsp_data),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    // PC, fetch FSM and ID slot; priority is redirect > flush > stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC & ~(XLEN'(3));
            fetch_pc <= '0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_pc4   <= '0;
            id_instr <= NOP_INSTR;
        end else begin
            if (fire)
                fetch_pc <= pc;
            if (redirect_valid)
                pc <= redirect_tgt;
            else if (fire)
                pc <= pc + XLEN'(4);

            // ID slot: a live word moves in unless stalled; otherwise it bubbles
            if (redirect_valid) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end else if (rsp_live && !stall) begin
                id_valid <= 1'b1;
                id_pc    <= fetch_pc;
                id_pc4   <= fetch_pc + XLEN'(4);
                id_instr <= imem_rsp_data;
            end else if (skid_drain) begin
                id_valid <= 1'b1;
                id_pc    <= skid_pc;
                id_pc4   <= skid_pc + XLEN'(4);
                id_instr <= skid_instr;
            end else if (flush || !stall) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end

            // A fetch still in flight after a redirect must be drained in S_DROP
            if (redirect_valid) begin
                if (fire || (((state == S_WAIT) || (state == S_DROP)) && !imem_rsp_valid))
                    state <= S_DROP;
                else
                    state <= S_REQ;
            end else begin
                case (state)
                    S_REQ:   if (fire) state <= S_WAIT;
                    S_WAIT:  if (imem_rsp_valid) state <= stall ? S_HOLD : S_REQ;
                    S_HOLD:  if (flush || !stall) state <= S_REQ;
                    S_DROP:  if (imem_rsp_valid) state <= S_REQ;
                    default: state <= S_REQ;
                endcase
            end
        end
    end

    assign Op     = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign funct7 = id_instr[31:25];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign rd     = id_instr[11:7];

endmodule
